// File: rtl/ifu_fetch_if.sv
// Memory-side fetch port of the IFU: one-word request channel and response channel,
// each with its own valid/ready handshake.
interface ifu_fetch_if;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_req_addr;
    logic        ifu_rsp_valid;
    logic        ifu_rsp_ready;
    logic [31:0] ifu_rsp_instr;
    logic        ifu_rsp_err;

    modport master (
        output ifu_req_valid,
        output ifu_req_addr,
        output ifu_rsp_ready,
        input  ifu_req_ready,
        input  ifu_rsp_valid,
        input  ifu_rsp_instr,
        input  ifu_rsp_err
    );

    modport slave (
        input  ifu_req_valid,
        input  ifu_req_addr,
        input  ifu_rsp_ready,
        output ifu_req_ready,
        output ifu_rsp_valid,
        output ifu_rsp_instr,
        output ifu_rsp_err
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: keeps the PC, issues one outstanding word fetch at a time and
// hands {instr, pc, err} to decode through a one-entry valid/ready register.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h8000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    ifu_fetch_if.master mem,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        fetch_halt,
    output logic        o_valid,
    input  logic        o_ready,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_err
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StFault} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    logic        req_pend_q, req_pend_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        o_valid_q, o_valid_d;
    logic [31:0] o_instr_q, o_instr_d;
    logic [31:0] o_pc_q, o_pc_d;
    logic        o_err_q, o_err_d;

    logic req_fire;
    logic rsp_fire;

    // A request once raised stays up with its original address until accepted, even if
    // fetch_halt rises or a redirect moves the PC underneath it.
    assign mem.ifu_req_valid = (state_q == StReq) & (req_pend_q | ~fetch_halt);
    assign mem.ifu_req_addr  = req_pend_q ? req_addr_q : pc_q;
    assign mem.ifu_rsp_ready = (state_q == StWait) & (~o_valid_q | o_ready);

    assign req_fire = mem.ifu_req_valid & mem.ifu_req_ready;
    assign rsp_fire = mem.ifu_rsp_valid & mem.ifu_rsp_ready;

    assign o_valid = o_valid_q;
    assign o_instr = o_instr_q;
    assign o_pc    = o_pc_q;
    assign o_err   = o_err_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        drop_d     = drop_q;
        req_pend_d = 1'b0;
        req_addr_d = req_addr_q;
        o_valid_d  = o_valid_q & ~o_ready;
        o_instr_d  = o_instr_q;
        o_pc_d     = o_pc_q;
        o_err_d    = o_err_q;

        unique case (state_q)
            StIdle: state_d = StReq;
            StReq: begin
                req_pend_d = mem.ifu_req_valid & ~mem.ifu_req_ready;
                req_addr_d = mem.ifu_req_addr;
                if (req_fire) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (rsp_fire) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = StReq;
                    end else begin
                        o_valid_d = 1'b1;
                        o_instr_d = mem.ifu_rsp_instr;
                        o_pc_d    = pc_q;
                        o_err_d   = mem.ifu_rsp_err;
                        if (mem.ifu_rsp_err) begin
                            state_d = StFault;
                        end else begin
                            pc_d    = pc_q + 32'd4;
                            state_d = StReq;
                        end
                    end
                end
            end
            StFault: state_d = StFault;
            default: state_d = StIdle;
        endcase

        // Redirect overrides everything; an in-flight fetch must still complete on the bus,
        // so its response is marked for discard rather than abandoned.
        if (redirect_valid) begin
            pc_d      = {redirect_pc[31:2], 2'b00};
            o_valid_d = 1'b0;
            o_instr_d = NOP_INSTR;
            o_pc_d    = o_pc_q;
            o_err_d   = o_err_q;
            if (state_q == StWait && !rsp_fire) begin
                drop_d  = 1'b1;
                state_d = StWait;
            end else if (state_q == StWait) begin
                drop_d  = 1'b0;
                state_d = StReq;
            end else if (state_q == StReq && req_fire) begin
                drop_d  = 1'b1;
                state_d = StWait;
            end else if (state_q == StReq && mem.ifu_req_valid) begin
                drop_d  = 1'b1;
                state_d = StReq;
            end else begin
                state_d = StReq;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            drop_q     <= 1'b0;
            req_pend_q <= 1'b0;
            req_addr_q <= RESET_PC;
            o_valid_q  <= 1'b0;
            o_instr_q  <= NOP_INSTR;
            o_pc_q     <= RESET_PC;
            o_err_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            drop_q     <= drop_d;
            req_pend_q <= req_pend_d;
            req_addr_q <= req_addr_d;
            o_valid_q  <= o_valid_d;
            o_instr_q  <= o_instr_d;
            o_pc_q     <= o_pc_d;
            o_err_q    <= o_err_d;
        end
    end

endmodule
